shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter sharing one DATA_W-bit D-flip-flop storage register between N_REQ requesters.
- Grants exclusive write access to one requester at a time and loads that requester's data into the register on its write strobe.
- Sits between requester logic and the D-FF register bank; the register output is a broadcast read port for all requesters.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the shared register and of each requester data slice.
- HOLD_MAX, 15, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req_in  input  N_REQ  per-requester access request, level-held.
- wr_en_in  input  N_REQ  per-requester write strobe.
- data_in  input  N_REQ*DATA_W  requester data; slice i = bits [i*DATA_W +: DATA_W].
- grant_out  output  N_REQ  one-hot grant, registered.
- busy_out  output  1  high while any grant is active.
- q_out  output  DATA_W  shared register contents.
- last_gnt_out  output  clog2(N_REQ)  index of most recently granted requester.

Behaviour:
- Reset (rst_n low at an edge): grant_out=0, busy_out=0, q_out=0, last_gnt_out=0, round-robin pointer=0, hold counter=0, state=IDLE. Reset mid-grant drops the grant on that edge; a pending write that cycle is discarded.
- FSM states:
  - IDLE: if any req_in bit is high, select the first requester at or after the pointer (circular search), set grant_out one-hot, busy_out=1, go to GRANT. Grant is visible 1 cycle after req is sampled.
  - GRANT (g = granted index): if req_in[g]=1 and wr_en_in[g]=1, q_out <= data_in slice g at that edge. Write only when all three of grant, req and wr_en are high. wr_en from non-granted requesters is ignored.
  - GRANT release: when req_in[g]=0 at an edge, clear grant_out, set busy_out=0, pointer <= (g+1) mod N_REQ, last_gnt_out <= g, go to IDLE.
  - Mandatory 1-cycle IDLE turnaround between grants; back-to-back grants never overlap.
- Simultaneous requests: the pointer decides. Requester g has lowest priority immediately after its own grant.
- Wrap-around: the pointer wraps from N_REQ-1 to 0.
- req drop with wr_en high in the same cycle: no write, release occurs.
- q_out holds its value across IDLE and across grants without writes.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter clears on grant entry and increments each GRANT cycle.
  - When the counter equals HOLD_MAX-1, force release on the next edge regardless of req_in[g]. Pointer and last_gnt_out update as in a normal release.
  - A write asserted in the final cycle is still performed.
  - A still-requesting g is regranted only if no other requester is active.
- Undefined: no counter; the grant is held indefinitely until req_in[g] drops.

Decomposition:
- Package shared_reg_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Index width constant derived via clog2(N_REQ).
  - Default N_REQ and DATA_W constants.
- Sub-module shared_reg_dff: DATA_W-bit D register with load enable and synchronous active-low reset. It is the storage instance driven by the arbiter's load and select mux.

Test Plan (N_REQ=4, DATA_W=8, HOLD_MAX=15):
1. Reset: hold rst_n=0 for 2 edges with req_in=4'b1111 -> grant_out=0, busy_out=0, q_out=8'h00 throughout.
2. Single requester:
   - Stimulus: req_in=4'b0100, wr_en_in[2]=1, slice 2=8'hA5 for 3 cycles, then req drops.
   - Expected: grant_out=4'b0100 one cycle after req; q_out=8'hA5; release the following edge; last_gnt_out=2.
3. Round-robin: req_in=4'b1111 held -> grant order 0,1,2,3,0 with one IDLE cycle between each; grant_out never has two bits set.
4. Rogue write:
   - Stimulus: requester 1 granted, wr_en_in[3]=1 with slice 3=8'hFF, wr_en_in[1]=0.
   - Expected: q_out unchanged.
   - Stimulus: requester 1 then writes 8'h3C.
   - Expected: q_out=8'h3C.
5. Timeout (ARB_TIMEOUT_EN):
   - Stimulus: req_in=4'b0011 held, requester 0 granted.
   - Expected: forced release after 15 GRANT cycles; requester 1 granted next.
   - Without the macro: requester 0 is held for 50+ cycles.
6. Mid-grant reset: rst_n=0 while requester 2 is writing 8'h77 -> grant_out=0, q_out=8'h00, pointer=0; after release of reset with req_in=4'b0100, requester 2 is regranted.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// shared_reg_arb_pkg
// Shared types and constants for the shared-register round-robin arbiter:
//   state_t   - arbiter FSM state (IDLE / GRANT)
//   DEF_*     - default requester count and data width
//   idx_w()   - index width for a given count (clog2, minimum 1 bit)
// ----------------------------------------------------------------------------
package shared_reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_N_REQ);

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// ----------------------------------------------------------------------------
// shared_reg_arbiter_if
// Requester-side bus of the shared register arbiter.
//   req_in       requester -> arbiter  per-requester level-held request
//   wr_en_in     requester -> arbiter  per-requester write strobe
//   data_in      requester -> arbiter  data, slice i = [i*DATA_W +: DATA_W]
//   grant_out    arbiter -> requester  one-hot registered grant
//   busy_out     arbiter -> requester  any grant active
//   q_out        arbiter -> requester  shared register (broadcast read)
//   last_gnt_out arbiter -> requester  index of most recent granted requester
// Modports: master (requester side), slave (arbiter side).
// ----------------------------------------------------------------------------
interface shared_reg_arbiter_if
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int IW = idx_w(N_REQ);

    logic [N_REQ-1:0]        req_in;
    logic [N_REQ-1:0]        wr_en_in;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant_out;
    logic                    busy_out;
    logic [DATA_W-1:0]       q_out;
    logic [IW-1:0]           last_gnt_out;

    modport master (
        output req_in, wr_en_in, data_in,
        input  grant_out, busy_out, q_out, last_gnt_out
    );

    modport slave (
        input  req_in, wr_en_in, data_in,
        output grant_out, busy_out, q_out, last_gnt_out
    );

endinterface

// File: rtl/shared_reg_arbiter_dff.sv
// ----------------------------------------------------------------------------
// shared_reg_dff
// DATA_W-bit storage register with load enable, synchronous active-low reset.
//   clk   rising-edge clock
//   rst_n synchronous active-low reset (clears the register)
//   i_ld  load enable
//   i_d   load data
//   o_q   register contents
// ----------------------------------------------------------------------------
module shared_reg_dff #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_ld)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// ----------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin arbiter giving N_REQ requesters exclusive write access to one
// shared DATA_W-bit register. The granted requester writes when its request
// and write strobe are both high; the register is broadcast on q_out.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    shared_reg_arbiter_if.slave (req/wr/data in, grant/busy/q/last out)
// Optional build macro ARB_TIMEOUT_EN: force a grant release after HOLD_MAX
// grant cycles so a requester holding req cannot starve the others.
// ----------------------------------------------------------------------------
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_reg_arbiter_if.slave  bus
);

    localparam int IW = idx_w(N_REQ);

    state_t            r_state;
    logic [N_REQ-1:0]  r_grant;
    logic              r_busy;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_last;
    logic [IW-1:0]     r_gidx;

    logic              w_found;
    logic [IW-1:0]     w_sel;
    logic [N_REQ-1:0]  w_sel_oh;
    logic [IW-1:0]     w_idx;
    logic              w_req_g;
    logic              w_wr_g;
    logic [DATA_W-1:0] w_d;
    logic              w_load;
    logic              w_to;
    logic              w_rel;
    logic [IW-1:0]     w_ptr_nxt;
    logic [DATA_W-1:0] w_q;

    // Circular search: first active request at or after the pointer.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_oh = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            w_idx = IW'(idx);
            if (!w_found && bus.req_in[w_idx]) begin
                w_found        = 1'b1;
                w_sel          = w_idx;
                w_sel_oh[idx]  = 1'b1;
            end
        end
    end

    // Granted requester's request, strobe and data slice.
    always_comb begin
        w_req_g = 1'b0;
        w_wr_g  = 1'b0;
        w_d     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gidx == IW'(i)) begin
                w_req_g = bus.req_in[i];
                w_wr_g  = bus.wr_en_in[i];
                w_d     = bus.data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write needs grant, req and strobe together; a final timeout cycle
    // still writes because the release does not gate the load.
    assign w_load    = (r_state == GRANT) && w_req_g && w_wr_g;
    assign w_ptr_nxt = (r_gidx == IW'(N_REQ-1)) ? '0 : r_gidx + IW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int HW = idx_w(HOLD_MAX);

    logic [HW-1:0] r_hold;

    // Zero while idle, so it starts at 0 on grant entry; counts each grant cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_hold <= '0;
        else if (r_state == IDLE)
            r_hold <= '0;
        else
            r_hold <= r_hold + HW'(1);
    end

    assign w_to = (r_state == GRANT) && (r_hold == HW'(HOLD_MAX-1));
`else
    // No hold limit: the grant lasts until the owner drops its request.
    assign w_to = (HOLD_MAX < 0);
`endif

    assign w_rel = !w_req_g || w_to;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_last  <= '0;
            r_gidx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel_oh;
                        r_gidx  <= w_sel;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // Pointer moves past the owner, giving it lowest priority next.
                    if (w_rel) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_nxt;
                        r_last  <= r_gidx;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    shared_reg_dff #(.DATA_W(DATA_W)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ld  (w_load),
        .i_d   (w_d),
        .o_q   (w_q)
    );

    assign bus.grant_out    = r_grant;
    assign bus.busy_out     = r_busy;
    assign bus.q_out        = w_q;
    assign bus.last_gnt_out = r_last;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shared_reg_arbiter
// Directed stimulus for shared_reg_arbiter (N_REQ=4, DATA_W=8, HOLD_MAX=15).
// The driver applies one input vector per cycle on the falling edge and
// queues the outputs expected after the next rising edge; the monitor pops
// and compares shortly after each rising edge.
// ----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

    logic clk;
    logic rst_n;

    shared_reg_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

    shared_reg_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_MAX(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] g;
        logic       b;
        logic [7:0] q;
        logic [1:0] l;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   step_id = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    // Monitor: compare after every rising edge that has a queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant", e.id, 32'(bus.grant_out),    32'(e.g));
            chk("busy",  e.id, 32'(bus.busy_out),     32'(e.b));
            chk("q",     e.id, 32'(bus.q_out),        32'(e.q));
            chk("last",  e.id, 32'(bus.last_gnt_out), 32'(e.l));
        end
    end

    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] wr,
                        input logic [31:0] d, input logic [3:0] eg, input logic eb,
                        input logic [7:0] eq, input logic [1:0] el);
        exp_t e;
        @(negedge clk);
        rst_n        = rst;
        bus.req_in   = req;
        bus.wr_en_in = wr;
        bus.data_in  = d;
        e.id = step_id; e.g = eg; e.b = eb; e.q = eq; e.l = el;
        sb.push_back(e);
        step_id++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] prev;
        logic [1:0] lst;
        logic [3:0] oh;
        rst_n        = 1'b0;
        bus.req_in   = '0;
        bus.wr_en_in = '0;
        bus.data_in  = '0;

        // Reset with every request active.
        step(0, 4'hF, 4'h0, 32'h0, 4'h0, 0, 8'h00, 2'd0);
        step(0, 4'hF, 4'h0, 32'h0, 4'h0, 0, 8'h00, 2'd0);
        step(1, 4'h0, 4'h0, 32'h0, 4'h0, 0, 8'h00, 2'd0);

        // Single requester 2 writes A5.
        step(1, 4'h4, 4'h4, 32'h00A5_0000, 4'h4, 1, 8'h00, 2'd0);
        step(1, 4'h4, 4'h4, 32'h00A5_0000, 4'h4, 1, 8'hA5, 2'd0);
        step(1, 4'h4, 4'h4, 32'h00A5_0000, 4'h4, 1, 8'hA5, 2'd0);
        step(1, 4'h0, 4'h0, 32'h0,         4'h0, 0, 8'hA5, 2'd2);
        step(1, 4'h0, 4'h0, 32'h0,         4'h0, 0, 8'hA5, 2'd2);

        // Round robin from pointer 0: owner drops req for one cycle to release.
        step(0, 4'h0, 4'h0, 32'h0, 4'h0, 0, 8'h00, 2'd0);
        prev = 2'd0;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            step(1, 4'hF,       4'h0, 32'h0, oh,   1, 8'h00, prev);
            step(1, 4'hF & ~oh, 4'h0, 32'h0, 4'h0, 0, 8'h00, 2'(k % 4));
            prev = 2'(k % 4);
        end

        // Rogue write from requester 3 while 1 owns the grant.
        step(1, 4'h2, 4'h0, 32'h0,         4'h2, 1, 8'h00, 2'd0);
        step(1, 4'hA, 4'h8, 32'hFF00_0000, 4'h2, 1, 8'h00, 2'd0);
        step(1, 4'hA, 4'h2, 32'h0000_3C00, 4'h2, 1, 8'h3C, 2'd0);
        // Request drop with strobe still high: release, no write.
        step(1, 4'h8, 4'h2, 32'h0000_1100, 4'h0, 0, 8'h3C, 2'd1);
        step(1, 4'h8, 4'h0, 32'h0,         4'h8, 1, 8'h3C, 2'd1);
        step(1, 4'h0, 4'h0, 32'h0,         4'h0, 0, 8'h3C, 2'd3);

        // Requesters 0 and 1 both hold req; 0 owns the grant.
        step(1, 4'h3, 4'h0, 32'h0, 4'h1, 1, 8'h3C, 2'd3);
`ifdef ARB_TIMEOUT_EN
        repeat (14) step(1, 4'h3, 4'h0, 32'h0, 4'h1, 1, 8'h3C, 2'd3);
        step(1, 4'h3, 4'h0, 32'h0, 4'h0, 0, 8'h3C, 2'd0);
        step(1, 4'h3, 4'h0, 32'h0, 4'h2, 1, 8'h3C, 2'd0);
        step(1, 4'h0, 4'h0, 32'h0, 4'h0, 0, 8'h3C, 2'd1);
        lst = 2'd1;
`else
        repeat (55) step(1, 4'h3, 4'h0, 32'h0, 4'h1, 1, 8'h3C, 2'd3);
        step(1, 4'h0, 4'h0, 32'h0, 4'h0, 0, 8'h3C, 2'd0);
        lst = 2'd0;
`endif

        // Reset while requester 2 writes 77.
        step(1, 4'h4, 4'h4, 32'h0077_0000, 4'h4, 1, 8'h3C, lst);
        step(1, 4'h4, 4'h4, 32'h0077_0000, 4'h4, 1, 8'h77, lst);
        step(0, 4'h4, 4'h4, 32'h0066_0000, 4'h0, 0, 8'h00, 2'd0);
        step(1, 4'h4, 4'h0, 32'h0,         4'h4, 1, 8'h00, 2'd0);
        step(1, 4'h0, 4'h0, 32'h0,         4'h0, 0, 8'h00, 2'd2);
        // Pointer restarts at 0 after reset: requests 1 and 3 -> 1 wins.
        step(0, 4'h0, 4'h0, 32'h0, 4'h0, 0, 8'h00, 2'd0);
        step(1, 4'hA, 4'h0, 32'h0, 4'h2, 1, 8'h00, 2'd0);
        step(1, 4'h0, 4'h0, 32'h0, 4'h0, 0, 8'h00, 2'd1);

        // Let the monitor drain the queue, bounded.
        for (int w = 0; w < 10 && sb.size() > 0; w++)
            @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
